otn_frame_tx: RTL and testbench
===============================

Name: otn_frame_tx

Overview:
- Transmit end of the serial OTN link. Accepts one frame payload per frame from the mapper over a valid/ready byte stream and stores it in an internal frame buffer.
- Serializes a 6-byte frame-start pattern followed by the payload onto `o_otn_tx_data` at the baud rate. Bytes are sent LSB first, with no per-byte start or stop bits.
- When ARQ is enabled, waits for the 3-bit ack from the far-end receiver and retransmits the buffered frame on a bad ack or timeout.

Parameters:
- `PAYLOAD_BYTES`, 4158: payload bytes per frame, excluding the start pattern.
- `ACK_TIMEOUT`, 65535: i_clk cycles to wait in `WAIT_ACK` before treating the frame as NAKed.
- `MAX_RETRY`, 3: retransmissions allowed after the first send before the frame is dropped.

Ports:
- `i_clk` input 1: system clock.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_sclk_en_16_x_baud` input 1: one-cycle strobe at 16x the baud rate.
- `i_frame_data` input 8: payload byte from the mapper.
- `i_frame_data_valid` input 1: payload byte valid.
- `o_frame_data_ready` output 1: block accepts a payload byte.
- `i_arq_en` input 1: ARQ enable value.
- `i_arq_en_valid` input 1: qualifier that updates the internal `arq_en` register.
- `i_otn_rx_ack` input 1: ack line from the receiver; idle high.
- `o_otn_tx_data` output 1: serial line; idle high.
- `o_busy` output 1: high in every state except `IDLE`/`LOAD`.
- `o_ack_good` output 1: one-cycle pulse when a good ack is decoded.
- `o_frame_drop` output 1: one-cycle pulse when a frame is abandoned after `MAX_RETRY`.

Behaviour:
- Reset values:
  - `o_otn_tx_data`=1, `o_frame_data_ready`=0, `o_busy`=0, `o_ack_good`=0, `o_frame_drop`=0.
  - State=`IDLE`; all counters=0; `arq_en`=0.
- Reset asserted mid-frame aborts at once: line goes high and the buffered frame is discarded.
- `arq_en` register: loads `i_arq_en` when `i_arq_en_valid`=1, otherwise holds. The value in effect is snapshotted on the `LOAD`→`SEND_FAS` transition and held for that frame including its retries.
- Baud tick: 4-bit `scount` increments on each `i_sclk_en_16_x_baud` while in `SEND_FAS` or `SEND_PAYLOAD`, and is held at 0 in all other states. Tick = strobe AND `scount`==15. Each line bit therefore lasts exactly 16 strobes.
- Buffer: `PAYLOAD_BYTES`x8 RAM written at address `wr_ptr`. The address counter is `$clog2(PAYLOAD_BYTES)` bits wide.
- States:
  - `IDLE`: `o_frame_data_ready`=0. Goes to `LOAD` the next cycle; `IDLE` is a one-cycle cleanup state (clears `wr_ptr`, `retry_cnt`).
  - `LOAD`:
    - `o_frame_data_ready`=1; a byte is written on valid&&ready and `wr_ptr` increments.
    - After byte `PAYLOAD_BYTES`-1 is accepted, ready drops in the same cycle and the state moves to `SEND_FAS`.
    - There is no timeout in `LOAD`.
  - `SEND_FAS`:
    - Shifts out F6,F6,F6,28,28,28, each byte LSB first.
    - First bit is driven on the first tick after entry; the line stays high until then.
    - After 48 bits, goes to `SEND_PAYLOAD`.
  - `SEND_PAYLOAD`:
    - Reads the buffer from address 0 upward.
    - Next byte is prefetched from the RAM so there is no gap between bytes.
    - After bit 7 of byte `PAYLOAD_BYTES`-1 has been held for its full 16 strobes, the line returns to 1.
    - Next state is `WAIT_ACK` if ARQ is enabled, else `IDLE`.
  - `WAIT_ACK`:
    - `i_otn_rx_ack` passes through a 2-flop synchronizer. The ack protocol runs at i_clk rate, one cycle per bit.
    - A sync'd 1→0 edge marks the start bit. The next cycle is the data bit (1=good, 0=bad). The cycle after that is the stop bit and must be 0.
    - Good ack → `o_ack_good` pulse, then `IDLE`.
    - Bad data bit, stop bit≠0, or timeout counter reaching `ACK_TIMEOUT` → `RETRY`.
    - The timeout counter starts at 0 on entry.
  - `RETRY`:
    - If `retry_cnt`==`MAX_RETRY`: `o_frame_drop` pulse, then `IDLE`.
    - Otherwise: `retry_cnt`++, then `SEND_FAS`, resending the same buffer contents.
- Simultaneous ack edge and timeout in the same cycle: the timeout wins.
- Any ack edge outside `WAIT_ACK` is ignored.
- `MAX_RETRY`=0 means a single attempt only.
- `o_busy`=1 in `SEND_FAS`, `SEND_PAYLOAD`, `WAIT_ACK` and `RETRY`.

Test Plan:
- `PAYLOAD_BYTES`=4, ARQ off, payload 01,80,A5,FF, strobe every cycle:
  - Line carries 80 bits LSB-first.
  - F6 appears as 0,1,1,0,1,1,1,1; each bit is held 16 cycles.
  - Line returns to 1 afterwards and the block returns to `IDLE`/`LOAD`.
- Mapper inserts `i_frame_data_valid` gaps of 0-5 cycles during `LOAD`:
  - Exactly 4 bytes are accepted.
  - `o_frame_data_ready` is 0 from the cycle after the 4th handshake until the next `LOAD`.
- ARQ on, inject ack 1→0,1,0 on `i_otn_rx_ack` after the frame → `o_ack_good` pulses once, no retransmission.
- ARQ on, inject ack 0,0,0 → identical frame retransmitted. Ack 0,1,0 on the retry → `o_ack_good` pulses.
- ARQ on, `MAX_RETRY`=2, no ack, `ACK_TIMEOUT`=100 → 3 transmissions in total, each ending with a 100-cycle wait; `o_frame_drop` pulses once.
- `i_rst` asserted during payload byte 2 → next cycle the line is 1 and all outputs are at reset values. After release, a new 4-byte `LOAD` starts cleanly.

Source files
------------

// File: rtl/otn_frame_tx_if.sv
// Mapper-to-framer payload byte stream: one byte per valid/ready handshake.
interface otn_frame_tx_if;
    logic [7:0] i_frame_data;
    logic       i_frame_data_valid;
    logic       o_frame_data_ready;

    modport master (
        output i_frame_data,
        output i_frame_data_valid,
        input  o_frame_data_ready
    );

    modport slave (
        input  i_frame_data,
        input  i_frame_data_valid,
        output o_frame_data_ready
    );
endinterface

// File: rtl/otn_frame_tx.sv
// OTN transmit framer: buffers one payload, serialises FAS + payload LSB-first at the baud
// rate, and with ARQ enabled waits for a 3-bit ack, retransmitting up to MAX_RETRY times.
module otn_frame_tx #(
    parameter int unsigned PAYLOAD_BYTES = 4158,
    parameter int unsigned ACK_TIMEOUT   = 65535,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sclk_en_16_x_baud,
    otn_frame_tx_if.slave frame_if,
    input  logic          i_arq_en,
    input  logic          i_arq_en_valid,
    input  logic          i_otn_rx_ack,
    output logic          o_otn_tx_data,
    output logic          o_busy,
    output logic          o_ack_good,
    output logic          o_frame_drop
);
    localparam int unsigned AW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned CW = (AW > 3) ? AW : 3;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PAYLOAD_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [CW-1:0] FAS_LAST  = CW'(5);

    typedef enum logic [2:0] {
        StIdle, StLoad, StSendFas, StSendPayload, StWaitAck, StRetry
    } state_e;

    typedef enum logic [1:0] {AckStart, AckData, AckStop} ack_ph_e;

    state_e          r_state, w_state_nxt;
    ack_ph_e         r_ack_ph, w_ack_ph_nxt;
    logic            r_arq_en, r_arq_frame, w_arq_frame_nxt;
    logic [3:0]      r_scount, w_scount_nxt;
    logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [CW-1:0]   r_byte_idx, w_byte_idx_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic            r_pay_done, w_pay_done_nxt;
    logic            r_tx, w_tx_nxt;
    logic [RW-1:0]   r_retry_cnt, w_retry_cnt_nxt;
    logic [TW-1:0]   r_to_cnt, w_to_cnt_nxt;
    logic            r_ack_s1, r_ack_s2, r_ack_prev;
    logic            r_ack_good, w_ack_good_nxt;
    logic            r_frame_drop, w_frame_drop_nxt;
    logic [7:0]      r_mem [PAYLOAD_BYTES];
    logic [7:0]      r_rd_data;
    logic            w_wr_en, w_tick, w_ack_fall;
    logic [7:0]      w_fas_byte;

    assign w_wr_en    = (r_state == StLoad) && frame_if.i_frame_data_valid;
    assign w_tick     = i_sclk_en_16_x_baud && (r_scount == 4'd15);
    assign w_ack_fall = r_ack_prev && !r_ack_s2;
    assign w_fas_byte = (r_byte_idx < CW'(3)) ? 8'hF6 : 8'h28;

    // Read port is registered every cycle; a new byte address is presented a full bit
    // period before it is needed, so the next byte is always ready without a gap.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= frame_if.i_frame_data;
        end
        r_rd_data <= r_mem[r_byte_idx[AW-1:0]];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_ack_ph     <= AckStart;
            r_arq_en     <= 1'b0;
            r_arq_frame  <= 1'b0;
            r_scount     <= 4'd0;
            r_wr_ptr     <= '0;
            r_byte_idx   <= '0;
            r_bit_idx    <= 3'd0;
            r_pay_done   <= 1'b0;
            r_tx         <= 1'b1;
            r_retry_cnt  <= '0;
            r_to_cnt     <= '0;
            r_ack_s1     <= 1'b1;
            r_ack_s2     <= 1'b1;
            r_ack_prev   <= 1'b1;
            r_ack_good   <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ack_ph     <= w_ack_ph_nxt;
            r_arq_en     <= i_arq_en_valid ? i_arq_en : r_arq_en;
            r_arq_frame  <= w_arq_frame_nxt;
            r_scount     <= w_scount_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_pay_done   <= w_pay_done_nxt;
            r_tx         <= w_tx_nxt;
            r_retry_cnt  <= w_retry_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_ack_s1     <= i_otn_rx_ack;
            r_ack_s2     <= r_ack_s1;
            r_ack_prev   <= r_ack_s2;
            r_ack_good   <= w_ack_good_nxt;
            r_frame_drop <= w_frame_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ack_ph_nxt     = AckStart;
        w_arq_frame_nxt  = r_arq_frame;
        w_scount_nxt     = 4'd0;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_byte_idx_nxt   = '0;
        w_bit_idx_nxt    = 3'd0;
        w_pay_done_nxt   = 1'b0;
        w_tx_nxt         = r_tx;
        w_retry_cnt_nxt  = r_retry_cnt;
        w_to_cnt_nxt     = '0;
        w_ack_good_nxt   = 1'b0;
        w_frame_drop_nxt = 1'b0;
        case (r_state)
            StIdle: begin
                w_wr_ptr_nxt    = '0;
                w_retry_cnt_nxt = '0;
                w_tx_nxt        = 1'b1;
                w_state_nxt     = StLoad;
            end
            StLoad: begin
                if (w_wr_en) begin
                    if (r_wr_ptr == LAST_ADDR) begin
                        w_wr_ptr_nxt    = '0;
                        w_arq_frame_nxt = r_arq_en;
                        w_state_nxt     = StSendFas;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                    end
                end
            end
            StSendFas: begin
                w_scount_nxt   = r_scount + {3'b000, i_sclk_en_16_x_baud};
                w_byte_idx_nxt = r_byte_idx;
                w_bit_idx_nxt  = r_bit_idx;
                if (w_tick) begin
                    w_tx_nxt      = w_fas_byte[r_bit_idx];
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        if (r_byte_idx == FAS_LAST) begin
                            w_byte_idx_nxt = '0;
                            w_state_nxt    = StSendPayload;
                        end else begin
                            w_byte_idx_nxt = r_byte_idx + CW'(1);
                        end
                    end
                end
            end
            StSendPayload: begin
                w_scount_nxt   = r_scount + {3'b000, i_sclk_en_16_x_baud};
                w_byte_idx_nxt = r_byte_idx;
                w_bit_idx_nxt  = r_bit_idx;
                w_pay_done_nxt = r_pay_done;
                if (w_tick) begin
                    // The tick after the last data bit returns the line to idle.
                    if (r_pay_done) begin
                        w_tx_nxt       = 1'b1;
                        w_pay_done_nxt = 1'b0;
                        w_byte_idx_nxt = '0;
                        w_state_nxt    = r_arq_frame ? StWaitAck : StIdle;
                    end else begin
                        w_tx_nxt      = r_rd_data[r_bit_idx];
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            if (r_byte_idx[AW-1:0] == LAST_ADDR) begin
                                w_pay_done_nxt = 1'b1;
                            end else begin
                                w_byte_idx_nxt = r_byte_idx + CW'(1);
                            end
                        end
                    end
                end
            end
            StWaitAck: begin
                // Timeout is checked first so it wins over a concurrent ack edge.
                if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = StRetry;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
                    w_ack_ph_nxt = r_ack_ph;
                    case (r_ack_ph)
                        AckStart: begin
                            if (w_ack_fall) begin
                                w_ack_ph_nxt = AckData;
                            end
                        end
                        AckData: begin
                            if (r_ack_s2) begin
                                w_ack_ph_nxt = AckStop;
                            end else begin
                                w_state_nxt = StRetry;
                            end
                        end
                        default: begin
                            if (!r_ack_s2) begin
                                w_ack_good_nxt = 1'b1;
                                w_state_nxt    = StIdle;
                            end else begin
                                w_state_nxt = StRetry;
                            end
                        end
                    endcase
                end
            end
            StRetry: begin
                if (r_retry_cnt == RETRY_MAX) begin
                    w_frame_drop_nxt = 1'b1;
                    w_state_nxt      = StIdle;
                end else begin
                    w_retry_cnt_nxt = r_retry_cnt + RW'(1);
                    w_state_nxt     = StSendFas;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign frame_if.o_frame_data_ready = (r_state == StLoad);
    assign o_otn_tx_data = r_tx;
    assign o_busy        = (r_state == StSendFas) || (r_state == StSendPayload) ||
                           (r_state == StWaitAck) || (r_state == StRetry);
    assign o_ack_good    = r_ack_good;
    assign o_frame_drop  = r_frame_drop;
endmodule

// File: tb/tb_otn_frame_tx.sv
// Directed bench for otn_frame_tx: 4-byte frames, strobe every cycle, ARQ ack/timeout/reset.
module tb_otn_frame_tx;
    localparam int unsigned PB = 4;
    localparam int unsigned TO = 100;
    localparam int unsigned MR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk_en, arq_en, arq_en_valid, rx_ack;
    logic tx_data, busy, ack_good, frame_drop;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;

    otn_frame_tx_if u_if ();

    otn_frame_tx #(
        .PAYLOAD_BYTES(PB),
        .ACK_TIMEOUT  (TO),
        .MAX_RETRY    (MR)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_sclk_en_16_x_baud(sclk_en),
        .frame_if           (u_if),
        .i_arq_en           (arq_en),
        .i_arq_en_valid     (arq_en_valid),
        .i_otn_rx_ack       (rx_ack),
        .o_otn_tx_data      (tx_data),
        .o_busy             (busy),
        .o_ack_good         (ack_good),
        .o_frame_drop       (frame_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (u_if.i_frame_data_valid && u_if.o_frame_data_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte i of payload is payload[8*i +: 8]; gap before byte i is gaps[3*i +: 3] cycles.
    task automatic load(input logic [31:0] payload, input logic [11:0] gaps);
        int n;
        for (int i = 0; i < 4; i++) begin
            u_if.i_frame_data_valid = 1'b0;
            repeat (gaps[3*i +: 3]) @(negedge clk);
            u_if.i_frame_data       = payload[8*i +: 8];
            u_if.i_frame_data_valid = 1'b1;
            n = 0;
            while (u_if.o_frame_data_ready !== 1'b1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("load_ready", 32'(u_if.o_frame_data_ready), 32'd1);
            @(negedge clk);
        end
        u_if.i_frame_data_valid = 1'b0;
    endtask

    // Waits for the first line low, then checks all 80 bits (16 samples each) and idle after.
    task automatic capture(input logic [31:0] payload, input string tag, output int lat);
        logic [79:0] exp_bits;
        logic [15:0] win;
        exp_bits = {payload, 48'h28_28_28_F6_F6_F6};
        lat = 0;
        while (tx_data !== 1'b0 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_start"}, 32'(tx_data), 32'd0);
        if (tx_data !== 1'b0) return;
        for (int n = 0; n < 80; n++) begin
            for (int k = 0; k < 16; k++) begin
                win[k] = tx_data;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, n), 32'(win), {16'd0, {16{exp_bits[n]}}});
        end
        check({tag, "_idle"}, 32'(tx_data), 32'd1);
    endtask

    task automatic set_arq(input logic v);
        arq_en       = v;
        arq_en_valid = 1'b1;
        @(negedge clk);
        arq_en_valid = 1'b0;
    endtask

    // seq[0] is the start bit, seq[1] the data bit, seq[2] the stop bit.
    task automatic send_ack(input logic [2:0] seq);
        for (int i = 0; i < 3; i++) begin
            rx_ack = seq[i];
            @(negedge clk);
        end
        rx_ack = 1'b1;
    endtask

    task automatic watch(input int cycles, output int n_good, output int n_drop,
                         output int n_low, output int drop_pos);
        n_good = 0;
        n_drop = 0;
        n_low = 0;
        drop_pos = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (ack_good === 1'b1) n_good++;
            if (frame_drop === 1'b1) begin
                n_drop++;
                drop_pos = i;
            end
            if (tx_data !== 1'b1) n_low++;
        end
    endtask

    initial begin
        int lat, a0, n_good, n_drop, n_low, pos, n;
        sclk_en = 1'b1;
        arq_en = 1'b0;
        arq_en_valid = 1'b0;
        rx_ack = 1'b1;
        u_if.i_frame_data = 8'h00;
        u_if.i_frame_data_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_data), 32'd1);
        check("rst_ready", 32'(u_if.o_frame_data_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack_good", 32'(ack_good), 32'd0);
        check("rst_drop", 32'(frame_drop), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_to_load_ready", 32'(u_if.o_frame_data_ready), 32'd1);
        check("idle_to_load_busy", 32'(busy), 32'd0);

        // Basic frame, ARQ off: 01,80,A5,FF
        load(32'hFF_A5_80_01, 12'd0);
        check("f1_busy", 32'(busy), 32'd1);
        capture(32'hFF_A5_80_01, "f1", lat);
        check("f1_latency", 32'(lat), 32'd16);
        check("f1_end_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("f1_reload_ready", 32'(u_if.o_frame_data_ready), 32'd1);

        // Valid gaps; extra byte offered after the 4th must not be taken
        a0 = acc_cnt;
        load(32'h3C_C3_5A_E7, {3'd1, 3'd3, 3'd0, 3'd5});
        u_if.i_frame_data = 8'hEE;
        u_if.i_frame_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("gap_ready_low", 32'(u_if.o_frame_data_ready), 32'd0);
            @(negedge clk);
        end
        u_if.i_frame_data_valid = 1'b0;
        check("gap_accepted", 32'(acc_cnt - a0), 32'd4);
        capture(32'h3C_C3_5A_E7, "f2", lat);
        check("f2_latency", 32'(lat), 32'd13);
        check("f2_end_busy", 32'(busy), 32'd0);

        // ARQ on, good ack
        set_arq(1'b1);
        load(32'h12_34_56_78, 12'd0);
        capture(32'h12_34_56_78, "f3", lat);
        check("f3_wait_busy", 32'(busy), 32'd1);
        send_ack(3'b010);
        watch(12, n_good, n_drop, n_low, pos);
        check("f3_ack_pulses", 32'(n_good), 32'd1);
        check("f3_no_resend", 32'(n_low), 32'd0);
        check("f3_no_drop", 32'(n_drop), 32'd0);
        check("f3_ready", 32'(u_if.o_frame_data_ready), 32'd1);

        // Bad ack then good ack on the retransmission
        load(32'h9A_BC_DE_F0, 12'd0);
        capture(32'h9A_BC_DE_F0, "f4a", lat);
        send_ack(3'b000);
        check("f4_retry_busy", 32'(busy), 32'd1);
        capture(32'h9A_BC_DE_F0, "f4b", lat);
        send_ack(3'b010);
        watch(12, n_good, n_drop, n_low, pos);
        check("f4_ack_pulses", 32'(n_good), 32'd1);
        check("f4_no_resend", 32'(n_low), 32'd0);
        check("f4_busy", 32'(busy), 32'd0);

        // No ack: 3 transmissions, each followed by a 100-cycle wait, then one drop
        load(32'h0F_F0_00_FF, 12'd0);
        capture(32'h0F_F0_00_FF, "f5a", lat);
        capture(32'h0F_F0_00_FF, "f5b", lat);
        check("f5b_latency", 32'(lat), 32'(TO + 17));
        capture(32'h0F_F0_00_FF, "f5c", lat);
        check("f5c_latency", 32'(lat), 32'(TO + 17));
        watch(130, n_good, n_drop, n_low, pos);
        check("f5_drop_pulses", 32'(n_drop), 32'd1);
        check("f5_drop_time", 32'(pos), 32'(TO + 1));
        check("f5_no_4th_send", 32'(n_low), 32'd0);
        check("f5_no_ack", 32'(n_good), 32'd0);
        check("f5_busy", 32'(busy), 32'd0);

        // Reset during payload byte 2
        load(32'h11_22_33_44, 12'd0);
        n = 0;
        while (tx_data !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("f6_start", 32'(tx_data), 32'd0);
        repeat (16 * 65 + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx_data), 32'd1);
        check("mid_rst_ready", 32'(u_if.o_frame_data_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack_good", 32'(ack_good), 32'd0);
        check("mid_rst_drop", 32'(frame_drop), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(u_if.o_frame_data_ready), 32'd1);
        load(32'hAA_55_0F_C3, 12'd0);
        capture(32'hAA_55_0F_C3, "f7", lat);
        check("f7_latency", 32'(lat), 32'd16);
        check("f7_arq_cleared", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
